// File: rtl/jacobi_mem_sched.sv
// Sweep scheduler for the Jacobi memory subsystem: read-address walk, delayed V write-back, bank ping-pong.
// Optional stall counter output enabled by defining JACOBI_SCHED_PERF_EN.
module jacobi_mem_sched #(
    parameter int PIPE_LAT = 4,
    parameter int ITER_W   = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [10:0]       num_rows,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              converged,
    input  logic              dp_ready,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_count,
    output logic              rd_valid,
    output logic [10:0]       y_rd_addr1,
    output logic [10:0]       y_rd_addr2,
    output logic [8:0]        v_rd_addr1,
    output logic [8:0]        v_rd_addr2,
    output logic              v_rd_sel,
    output logic [7:0]        i_rd_addr1,
    output logic [7:0]        i_rd_addr2,
    output logic [8:0]        v_wr_addr1,
    output logic [8:0]        v_wr_addr2,
    output logic              we_1,
    output logic              we_2,
    output logic              we_3,
    output logic              we_4,
`ifdef JACOBI_SCHED_PERF_EN
    output logic [15:0]       stall_cycles,
`endif
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } stateT;

    stateT state, stateNext;

    logic [10:0]       rowPtr;
    logic [10:0]       numRowsQ;
    logic [ITER_W-1:0] maxIterQ;
    logic [ITER_W-1:0] iterCount;
    logic [ITER_W-1:0] iterNext;
    logic              parity;
    logic              busyQ;
    logic              rdValid;
    logic              finish;
    logic              pipeBusy;
    logic [10:0]       evenRows;
    logic [9:0]        rowHalf;
    logic [9:0]        rowHalfNext;
    logic [9:0]        halfRows;

    // Write-back delay line: one entry per cycle, {valid, row-pair address, destination select}.
    logic [PIPE_LAT-1:0] validPipe;
    logic [PIPE_LAT-1:0] dstPipe;
    logic [8:0]          addrPipe [PIPE_LAT];

    assign evenRows    = num_rows & 11'h7FE;
    assign rdValid     = (state == READ) && dp_ready;
    assign iterNext    = iterCount + ITER_W'(1);
    assign finish      = converged || (iterNext == maxIterQ);
    assign rowHalf     = rowPtr[10:1];
    assign rowHalfNext = rowHalf + 10'd1;
    assign halfRows    = numRowsQ[10:1];

    // Entries ahead of the output stage; once these are empty the last write-back is on the bus.
    always_comb begin
        pipeBusy = 1'b0;
        for (int i = 0; i < PIPE_LAT - 1; i++) begin
            pipeBusy = pipeBusy | validPipe[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (evenRows == 11'd0) ? DONE : READ;
                end
            end
            READ: begin
                if (rdValid && ((rowPtr + 11'd2) == numRowsQ)) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipeBusy) begin
                    stateNext = CHECK;
                end
            end
            CHECK: begin
                stateNext = finish ? DONE : READ;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rowPtr    <= 11'd0;
            numRowsQ  <= 11'd0;
            maxIterQ  <= '0;
            iterCount <= '0;
            parity    <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        numRowsQ  <= evenRows;
                        maxIterQ  <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                        iterCount <= '0;
                        parity    <= 1'b0;
                        rowPtr    <= 11'd0;
                        busyQ     <= 1'b1;
                    end
                end
                READ: begin
                    if (rdValid) begin
                        rowPtr <= rowPtr + 11'd2;
                    end
                end
                CHECK: begin
                    iterCount <= iterNext;
                    if (!finish) begin
                        parity <= ~parity;
                        rowPtr <= 11'd0;
                    end
                end
                DONE: begin
                    busyQ <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            validPipe <= '0;
            dstPipe   <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                addrPipe[i] <= 9'd0;
            end
        end else begin
            validPipe[0] <= rdValid;
            dstPipe[0]   <= parity;
            addrPipe[0]  <= rowHalf[8:0];
            for (int i = 1; i < PIPE_LAT; i++) begin
                validPipe[i] <= validPipe[i-1];
                dstPipe[i]   <= dstPipe[i-1];
                addrPipe[i]  <= addrPipe[i-1];
            end
        end
    end

`ifdef JACOBI_SCHED_PERF_EN
    logic [15:0] stallCount;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stallCount <= 16'd0;
        end else if ((state == IDLE) && start) begin
            stallCount <= 16'd0;
        end else if ((state == READ) && !dp_ready && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end

    assign stall_cycles = stallCount;
`endif

    // Read addresses are zero outside READ; the output stage of the delay line drives the write side.
    always_comb begin
        busy       = busyQ;
        done       = (state == DONE);
        iter_count = iterCount;
        dbg_state  = state;
        rd_valid   = rdValid;
        y_rd_addr1 = 11'd0;
        y_rd_addr2 = 11'd0;
        v_rd_addr1 = 9'd0;
        v_rd_addr2 = 9'd0;
        v_rd_sel   = 1'b0;
        i_rd_addr1 = 8'd0;
        i_rd_addr2 = 8'd0;
        if (state == READ) begin
            y_rd_addr1 = rowPtr;
            y_rd_addr2 = rowPtr + 11'd1;
            v_rd_addr1 = rowHalf[8:0];
            v_rd_addr2 = (rowHalfNext == halfRows) ? 9'd0 : rowHalfNext[8:0];
            v_rd_sel   = parity;
            i_rd_addr1 = rowHalf[7:0];
            i_rd_addr2 = rowHalf[7:0] + 8'd1;
        end
        v_wr_addr1 = validPipe[PIPE_LAT-1] ? addrPipe[PIPE_LAT-1] : 9'd0;
        v_wr_addr2 = v_wr_addr1;
        we_1       = validPipe[PIPE_LAT-1] & dstPipe[PIPE_LAT-1];
        we_2       = validPipe[PIPE_LAT-1] & dstPipe[PIPE_LAT-1];
        we_3       = validPipe[PIPE_LAT-1] & ~dstPipe[PIPE_LAT-1];
        we_4       = validPipe[PIPE_LAT-1] & ~dstPipe[PIPE_LAT-1];
    end

endmodule

// File: tb/tb_jacobi_mem_sched.sv
// Scoreboard bench for jacobi_mem_sched: directed runs push expected reads, write-backs and done events;
// a negedge monitor pops and compares whenever the scheduler presents one.
module tb_jacobi_mem_sched;

    localparam int PL = 4;
    localparam int IW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [10:0]   num_rows = 11'd0;
    logic [IW-1:0] max_iter = '0;
    logic          converged = 1'b0;
    logic          dp_ready = 1'b0;
    logic          busy, done, rd_valid, v_rd_sel;
    logic [IW-1:0] iter_count;
    logic [10:0]   y_rd_addr1, y_rd_addr2;
    logic [8:0]    v_rd_addr1, v_rd_addr2, v_wr_addr1, v_wr_addr2;
    logic [7:0]    i_rd_addr1, i_rd_addr2;
    logic          we_1, we_2, we_3, we_4;
    logic [2:0]    dbg_state;
`ifdef JACOBI_SCHED_PERF_EN
    logic [15:0]   stall_cycles;
`endif

    jacobi_mem_sched #(.PIPE_LAT(PL), .ITER_W(IW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .num_rows(num_rows),
        .max_iter(max_iter), .converged(converged), .dp_ready(dp_ready),
        .busy(busy), .done(done), .iter_count(iter_count), .rd_valid(rd_valid),
        .y_rd_addr1(y_rd_addr1), .y_rd_addr2(y_rd_addr2),
        .v_rd_addr1(v_rd_addr1), .v_rd_addr2(v_rd_addr2), .v_rd_sel(v_rd_sel),
        .i_rd_addr1(i_rd_addr1), .i_rd_addr2(i_rd_addr2),
        .v_wr_addr1(v_wr_addr1), .v_wr_addr2(v_wr_addr2),
        .we_1(we_1), .we_2(we_2), .we_3(we_3), .we_4(we_4),
`ifdef JACOBI_SCHED_PERF_EN
        .stall_cycles(stall_cycles),
`endif
        .dbg_state(dbg_state)
    );

    // Clock / cycle counter: cyc equals the number of rising edges seen so far.
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] c;
        logic [10:0] y1;
        logic [10:0] y2;
        logic [8:0]  v1;
        logic [8:0]  v2;
        logic        sel;
        logic [7:0]  i1;
        logic [7:0]  i2;
    } rd_t;

    typedef struct packed {
        logic [31:0] c;
        logic [3:0]  we;
        logic [8:0]  a1;
        logic [8:0]  a2;
    } wr_t;

    typedef struct packed {
        logic [31:0]   c;
        logic [IW-1:0] iter;
    } done_t;

    rd_t   rd_exp_q[$];
    wr_t   wr_exp_q[$];
    done_t done_exp_q[$];

    int vecs = 0;
    int errs = 0;
    int done_cnt = 0;
    bit mon_on = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected-value builders derived from the address rules of the scheduler.
    task automatic push_read(input int c, input int r, input int n, input bit sel);
        rd_t e;
        int  rh, nx;
        rh = r / 2;
        nx = (rh + 1 == n / 2) ? 0 : rh + 1;
        e.c   = 32'(c);
        e.y1  = 11'(r);
        e.y2  = 11'(r + 1);
        e.v1  = 9'(rh);
        e.v2  = 9'(nx);
        e.sel = sel;
        e.i1  = 8'(rh % 256);
        e.i2  = 8'((rh + 1) % 256);
        rd_exp_q.push_back(e);
    endtask

    task automatic push_write(input int c, input int r, input bit par);
        wr_t e;
        e.c  = 32'(c);
        e.we = par ? 4'b1100 : 4'b0011;
        e.a1 = 9'(r / 2);
        e.a2 = 9'(r / 2);
        wr_exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int s, input int n, input int it, input bit par);
        int base;
        base = s + it * (n / 2 + PL + 1);
        for (int k = 0; k < n / 2; k++) begin
            push_read(base + k, 2 * k, n, par);
            push_write(base + k + PL, 2 * k, par);
        end
    endtask

    task automatic push_done(input int c, input int iter);
        done_t e;
        e.c    = 32'(c);
        e.iter = IW'(iter);
        done_exp_q.push_back(e);
    endtask

    // Monitor: pops an expectation for every presented read, write-back and done pulse.
    rd_t   rd_act, rd_exp;
    wr_t   wr_act, wr_exp;
    done_t dn_act, dn_exp;

    always @(negedge clock) begin
        if (mon_on) begin
            if (rd_valid) begin
                rd_act = {32'(cyc), y_rd_addr1, y_rd_addr2, v_rd_addr1, v_rd_addr2, v_rd_sel, i_rd_addr1, i_rd_addr2};
                if (rd_exp_q.size() == 0) begin
                    check("rd_unexpected", 128'(rd_act), 128'(0));
                end else begin
                    rd_exp = rd_exp_q.pop_front();
                    check("rd", 128'(rd_act), 128'(rd_exp));
                end
            end
            if (we_1 | we_2 | we_3 | we_4) begin
                wr_act = {32'(cyc), we_1, we_2, we_3, we_4, v_wr_addr1, v_wr_addr2};
                if (wr_exp_q.size() == 0) begin
                    check("wr_unexpected", 128'(wr_act), 128'(0));
                end else begin
                    wr_exp = wr_exp_q.pop_front();
                    check("wr", 128'(wr_act), 128'(wr_exp));
                end
            end
            if (done) begin
                done_cnt++;
                dn_act = {32'(cyc), iter_count};
                if (done_exp_q.size() == 0) begin
                    check("done_unexpected", 128'(dn_act), 128'(0));
                end else begin
                    dn_exp = done_exp_q.pop_front();
                    check("done", 128'(dn_act), 128'(dn_exp));
                end
            end
        end
    end

    // Driver tasks
    task automatic start_run(input int n, input int mi, output int s);
        @(posedge clock); #1;
        start    = 1'b1;
        num_rows = 11'(n);
        max_iter = IW'(mi);
        @(posedge clock); #1;
        start = 1'b0;
        s     = cyc;
    endtask

    task automatic wait_done(input int budget);
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clock);
            if (done_cnt != d0) seen = 1'b1;
        end
        #1;
        if (!seen) begin
            vecs++;
            errs++;
            $display("FAIL done_timeout: got no done within %0d cycles, required one", budget);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int s;

    initial begin
        // Reset
        reset_n  = 1'b0;
        dp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_rd_valid", 128'(rd_valid), 128'(0));
        check("rst_iter", 128'(iter_count), 128'(0));
        check("rst_we", 128'({we_1, we_2, we_3, we_4}), 128'(0));
        check("rst_yaddr", 128'(y_rd_addr1), 128'(0));
        check("rst_state", 128'(dbg_state), 128'(0));
        reset_n = 1'b1;
        mon_on  = 1'b1;
        idle_cycles(2);

        // Single sweep, 8 rows
        start_run(8, 1, s);
        push_sweep(s, 8, 0, 1'b0);
        push_done(s + 9, 1);
        check("busy_during_run", 128'(busy), 128'(1));
        wait_done(100);
        idle_cycles(1);
        check("busy_after_done", 128'(busy), 128'(0));
        check("iter_held_1", 128'(iter_count), 128'(1));

        // Three sweeps with bank ping-pong; a start pulse mid-run must be ignored
        start_run(8, 3, s);
        push_sweep(s, 8, 0, 1'b0);
        push_sweep(s, 8, 1, 1'b1);
        push_sweep(s, 8, 2, 1'b0);
        push_done(s + 27, 3);
        idle_cycles(5);
        start    = 1'b1;
        num_rows = 11'd2;
        max_iter = IW'(1);
        idle_cycles(1);
        start = 1'b0;
        wait_done(100);
        idle_cycles(1);
        check("iter_held_3", 128'(iter_count), 128'(3));

        // Convergence at the first CHECK
        converged = 1'b1;
        start_run(8, 3, s);
        push_sweep(s, 8, 0, 1'b0);
        push_done(s + 9, 1);
        wait_done(100);
        converged = 1'b0;
        idle_cycles(2);

        // Back-pressure: dp_ready 1,0,0,1,...
        start_run(8, 1, s);
        push_read(s, 0, 8, 1'b0);
        push_read(s + 3, 2, 8, 1'b0);
        push_read(s + 4, 4, 8, 1'b0);
        push_read(s + 5, 6, 8, 1'b0);
        push_write(s + 4, 0, 1'b0);
        push_write(s + 7, 2, 1'b0);
        push_write(s + 8, 4, 1'b0);
        push_write(s + 9, 6, 1'b0);
        push_done(s + 11, 1);
        idle_cycles(1);
        dp_ready = 1'b0;
        idle_cycles(2);
        dp_ready = 1'b1;
        wait_done(100);
`ifdef JACOBI_SCHED_PERF_EN
        check("stall_cycles", 128'(stall_cycles), 128'(2));
`endif
        idle_cycles(2);

        // Reset two cycles after the first write-back
        start_run(8, 1, s);
        push_sweep(s, 8, 0, 1'b0);
        void'(wr_exp_q.pop_back());
        void'(wr_exp_q.pop_back());
        idle_cycles(6);
        reset_n = 1'b0;
        #1;
        check("midrst_we", 128'({we_1, we_2, we_3, we_4}), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_state", 128'(dbg_state), 128'(0));
        idle_cycles(2);
        reset_n = 1'b1;
        idle_cycles(2);

        // Clean two-sweep run after reset, 4 rows
        start_run(4, 2, s);
        push_sweep(s, 4, 0, 1'b0);
        push_sweep(s, 4, 1, 1'b1);
        push_done(s + 14, 2);
        wait_done(100);
        idle_cycles(3);
        check("iter_held_2", 128'(iter_count), 128'(2));

        // max_iter = 0 behaves as one iteration
        start_run(4, 0, s);
        push_sweep(s, 4, 0, 1'b0);
        push_done(s + 7, 1);
        wait_done(100);
        idle_cycles(2);

        // num_rows = 1 forces an empty sweep
        start_run(1, 5, s);
        push_done(s, 0);
        wait_done(20);
        idle_cycles(1);
        check("empty_busy", 128'(busy), 128'(0));
        check("empty_iter", 128'(iter_count), 128'(0));

        // Odd row count 515 -> 514 rows: I address wrap at 256 and V port-2 wrap at 257
        start_run(515, 1, s);
        push_sweep(s, 514, 0, 1'b0);
        push_done(s + 257 + PL + 1, 1);
        wait_done(400);
        idle_cycles(PL + 2);

        check("rd_q_empty", 128'(rd_exp_q.size()), 128'(0));
        check("wr_q_empty", 128'(wr_exp_q.size()), 128'(0));
        check("done_q_empty", 128'(done_exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
